// File: rtl/axi_pkg.sv
// Shared AXI constants and FSM state type for the cache-line AXI master.
package axi_pkg;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [2:0] SIZE_4B    = 3'd2;
    localparam logic [7:0] LEN_LINE   = 8'd3;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    typedef enum logic [2:0] {
        S_IDLE,
        S_AR,
        S_R,
        S_AW,
        S_W,
        S_B
    } state_e;

endpackage

// File: rtl/axi_line_master.sv
// Executes one 128-bit cache-line read or write as a 4-beat AXI4 INCR burst
// and stalls the caches through core_WAIT_o while the burst is in flight.
module axi_line_master
    import axi_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LINE_W = 128
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                bc_valid_req_i,
    input  logic                bc_rw_i,
    input  logic [ADDR_W-1:0]   bc_addr_i,
    input  logic [LINE_W-1:0]   bc_data_i,
    output logic [LINE_W-1:0]   axi_data_o,
    output logic                axi_rd_over_o,
    output logic                axi_wr_over_o,
    output logic                core_WAIT_o,
    output logic                axi_err_o,
    output logic [ADDR_W-1:0]   m_araddr,
    output logic [7:0]          m_arlen,
    output logic [2:0]          m_arsize,
    output logic [1:0]          m_arburst,
    output logic                m_arvalid,
    input  logic                m_arready,
    input  logic [DATA_W-1:0]   m_rdata,
    input  logic [1:0]          m_rresp,
    input  logic                m_rlast,
    input  logic                m_rvalid,
    output logic                m_rready,
    output logic [ADDR_W-1:0]   m_awaddr,
    output logic [7:0]          m_awlen,
    output logic [2:0]          m_awsize,
    output logic [1:0]          m_awburst,
    output logic                m_awvalid,
    input  logic                m_awready,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_wstrb,
    output logic                m_wlast,
    output logic                m_wvalid,
    input  logic                m_wready,
    input  logic [1:0]          m_bresp,
    input  logic                m_bvalid,
    output logic                m_bready
);

    localparam int              BEATS    = LINE_W / DATA_W;
    localparam int              CNT_W    = $clog2(BEATS);
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(BEATS - 1);
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(LINE_W / 8 - 1);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [LINE_W-1:0]   line_q, line_d;
    logic [LINE_W-1:0]   rdline_q, rdline_d;
    logic                rd_over_q, rd_over_d;
    logic                wr_over_q, wr_over_d;
    logic                err_q, err_d;
    logic                arvalid_q, awvalid_q, wvalid_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            line_q    <= '0;
            rdline_q  <= '0;
            rd_over_q <= 1'b0;
            wr_over_q <= 1'b0;
            err_q     <= 1'b0;
            arvalid_q <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            line_q    <= line_d;
            rdline_q  <= rdline_d;
            rd_over_q <= rd_over_d;
            wr_over_q <= wr_over_d;
            err_q     <= err_d;
            // Valids are registered copies of the next state, so they drop
            // in the same edge that completes their handshake.
            arvalid_q <= (state_d == S_AR);
            awvalid_q <= (state_d == S_AW);
            wvalid_q  <= (state_d == S_W);
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        line_d    = line_q;
        rdline_d  = rdline_q;
        rd_over_d = 1'b0;
        wr_over_d = 1'b0;
        err_d     = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (bc_valid_req_i) begin
                    addr_d  = bc_addr_i & ~OFF_MASK;
                    line_d  = bc_data_i;
                    cnt_d   = '0;
                    state_d = bc_rw_i ? S_AR : S_AW;
                end
            end
            S_AR: if (m_arready) state_d = S_R;
            S_R: begin
                if (m_rvalid) begin
                    line_d[DATA_W*cnt_q +: DATA_W] = m_rdata;
                    cnt_d = cnt_q + 1'b1;
                    if (m_rresp != RESP_OKAY || m_rlast != (cnt_q == LAST)) begin
                        err_d = 1'b1;
                    end
                    if (cnt_q == LAST) begin
                        rdline_d  = line_d;
                        rd_over_d = 1'b1;
                        state_d   = S_IDLE;
                    end
                end
            end
            S_AW: if (m_awready) state_d = S_W;
            S_W: begin
                if (m_wready) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST) state_d = S_B;
                end
            end
            S_B: begin
                if (m_bvalid) begin
                    if (m_bresp != RESP_OKAY) err_d = 1'b1;
                    wr_over_d = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign m_araddr  = addr_q;
    assign m_arlen   = arvalid_q ? LEN_LINE : '0;
    assign m_arsize  = arvalid_q ? SIZE_4B : '0;
    assign m_arburst = arvalid_q ? BURST_INCR : '0;
    assign m_arvalid = arvalid_q;
    assign m_rready  = (state_q == S_R);

    assign m_awaddr  = addr_q;
    assign m_awlen   = awvalid_q ? LEN_LINE : '0;
    assign m_awsize  = awvalid_q ? SIZE_4B : '0;
    assign m_awburst = awvalid_q ? BURST_INCR : '0;
    assign m_awvalid = awvalid_q;

    assign m_wdata   = wvalid_q ? line_q[DATA_W*cnt_q +: DATA_W] : '0;
    assign m_wstrb   = wvalid_q ? '1 : '0;
    assign m_wlast   = wvalid_q && (cnt_q == LAST);
    assign m_wvalid  = wvalid_q;
    assign m_bready  = (state_q == S_B);

    assign axi_data_o    = rdline_q;
    assign axi_rd_over_o = rd_over_q;
    assign axi_wr_over_o = wr_over_q;
    assign axi_err_o     = err_q;
    assign core_WAIT_o   = (state_q != S_IDLE) | rd_over_q | wr_over_q;

endmodule

// File: tb/tb_axi_line_master.sv
// Directed + randomized bench for axi_line_master; the bench acts as the AXI
// slave in lockstep and predicts line data, addresses and the sticky error.
module tb_axi_line_master;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         bc_valid_req_i = 1'b0;
    logic         bc_rw_i = 1'b0;
    logic [31:0]  bc_addr_i = '0;
    logic [127:0] bc_data_i = '0;
    logic [127:0] axi_data_o;
    logic         axi_rd_over_o, axi_wr_over_o, core_WAIT_o, axi_err_o;
    logic [31:0]  m_araddr, m_awaddr, m_wdata;
    logic [7:0]   m_arlen, m_awlen;
    logic [2:0]   m_arsize, m_awsize;
    logic [1:0]   m_arburst, m_awburst;
    logic         m_arvalid, m_awvalid, m_wvalid, m_wlast, m_rready, m_bready;
    logic [3:0]   m_wstrb;
    logic         m_arready = 1'b0, m_awready = 1'b0, m_wready = 1'b0;
    logic [31:0]  m_rdata = '0;
    logic [1:0]   m_rresp = '0, m_bresp = '0;
    logic         m_rlast = 1'b0, m_rvalid = 1'b0, m_bvalid = 1'b0;

    int unsigned  errors = 0;
    int unsigned  checks = 0;
    logic         exp_err = 1'b0;
    logic [127:0] exp_data = '0;

    always #5 clk = ~clk;

    axi_line_master #(.ADDR_W(32), .DATA_W(32), .LINE_W(128)) dut (
        .clk(clk), .rst_n(rst_n),
        .bc_valid_req_i(bc_valid_req_i), .bc_rw_i(bc_rw_i),
        .bc_addr_i(bc_addr_i), .bc_data_i(bc_data_i),
        .axi_data_o(axi_data_o), .axi_rd_over_o(axi_rd_over_o),
        .axi_wr_over_o(axi_wr_over_o), .core_WAIT_o(core_WAIT_o),
        .axi_err_o(axi_err_o),
        .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
        .m_arburst(m_arburst), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
        .m_rvalid(m_rvalid), .m_rready(m_rready),
        .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize),
        .m_awburst(m_awburst), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
        .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // AR attributes every read burst must present.
    task automatic chk_ar(input logic [31:0] exp_addr);
        chk("ar_valid", m_arvalid, 1'b1);
        chk("ar_addr", m_araddr, exp_addr);
        chk("ar_attr", {m_arlen, m_arsize, m_arburst}, {8'd3, 3'd2, 2'b01});
        chk("ar_no_r", m_rready, 1'b0);
        chk("ar_wait", core_WAIT_o, 1'b1);
    endtask

    task automatic read_txn(input logic [31:0] addr, input int ar_stall, input int err_beat,
                            input bit fixed, input bit pre_strobed, input bit strobe_in_r,
                            input bit chain, input logic [31:0] next_addr);
        logic [31:0] beats [4];
        for (int i = 0; i < 4; i++) beats[i] = fixed ? 32'h1111_1111 * (i + 1) : $urandom;
        if (!pre_strobed) begin
            bc_valid_req_i = 1'b1; bc_rw_i = 1'b1; bc_addr_i = addr;
            bc_data_i = {$urandom, $urandom, $urandom, $urandom};
            tick();
            bc_valid_req_i = 1'b0;
        end
        chk_ar(addr & 32'hFFFF_FFF0);
        for (int s = 0; s < ar_stall; s++) begin
            tick();
            chk("ar_hold_valid", m_arvalid, 1'b1);
            chk("ar_hold_addr", m_araddr, addr & 32'hFFFF_FFF0);
            chk("ar_hold_no_r", m_rready, 1'b0);
        end
        m_arready = 1'b1;
        tick();
        m_arready = 1'b0;
        chk("ar_drop", m_arvalid, 1'b0);
        for (int i = 0; i < 4; i++) begin
            chk("r_ready", m_rready, 1'b1);
            m_rvalid = 1'b1; m_rdata = beats[i]; m_rlast = (i == 3);
            m_rresp = (i == err_beat) ? 2'b10 : 2'b00;
            if (i == err_beat) exp_err = 1'b1;
            if (strobe_in_r && i == 1) begin
                bc_valid_req_i = 1'b1; bc_rw_i = 1'b0; bc_addr_i = $urandom;
            end
            tick();
            bc_valid_req_i = 1'b0;
        end
        m_rvalid = 1'b0; m_rlast = 1'b0; m_rresp = 2'b00;
        exp_data = {beats[3], beats[2], beats[1], beats[0]};
        chk("rd_over", axi_rd_over_o, 1'b1);
        chk("rd_data", axi_data_o, exp_data);
        chk("rd_over_wait", core_WAIT_o, 1'b1);
        chk("rd_err", axi_err_o, exp_err);
        chk("rd_no_wr_over", axi_wr_over_o, 1'b0);
        if (chain) begin
            bc_valid_req_i = 1'b1; bc_rw_i = 1'b1; bc_addr_i = next_addr;
            tick();
            bc_valid_req_i = 1'b0;
        end else begin
            tick();
            chk("rd_over_pulse", axi_rd_over_o, 1'b0);
            chk("rd_idle_wait", core_WAIT_o, 1'b0);
            chk("rd_no_aw", m_awvalid, 1'b0);
            chk("rd_data_hold", axi_data_o, exp_data);
        end
    endtask

    task automatic write_txn(input logic [31:0] addr, input logic [127:0] line,
                             input int stall_beat, input int stall_cycles,
                             input logic [1:0] bresp, input int rst_beat);
        bc_valid_req_i = 1'b1; bc_rw_i = 1'b0; bc_addr_i = addr; bc_data_i = line;
        tick();
        bc_valid_req_i = 1'b0; bc_data_i = {$urandom, $urandom, $urandom, $urandom};
        chk("aw_valid", m_awvalid, 1'b1);
        chk("aw_addr", m_awaddr, addr & 32'hFFFF_FFF0);
        chk("aw_attr", {m_awlen, m_awsize, m_awburst}, {8'd3, 3'd2, 2'b01});
        chk("aw_no_w", m_wvalid, 1'b0);
        chk("aw_wait", core_WAIT_o, 1'b1);
        m_awready = 1'b1;
        tick();
        m_awready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == rst_beat) begin
                chk("w_pre_rst", m_wvalid, 1'b1);
                rst_n = 1'b0;
                tick();
                exp_err = 1'b0; exp_data = '0;
                chk("rst_valids", {m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready}, 5'b0);
                chk("rst_pulses", {axi_rd_over_o, axi_wr_over_o, core_WAIT_o, axi_err_o}, 4'b0);
                chk("rst_data", axi_data_o, exp_data);
                rst_n = 1'b1;
                tick();
                chk("post_rst_pulses", {axi_rd_over_o, axi_wr_over_o, core_WAIT_o}, 3'b0);
                return;
            end
            for (int s = 0; (i == stall_beat) && (s < stall_cycles); s++) begin
                chk("w_stall_valid", m_wvalid, 1'b1);
                chk("w_stall_data", m_wdata, line[32*i +: 32]);
                tick();
            end
            chk("w_valid", m_wvalid, 1'b1);
            chk("w_data", m_wdata, line[32*i +: 32]);
            chk("w_strb", m_wstrb, 4'hF);
            chk("w_last", m_wlast, (i == 3));
            chk("w_no_b", m_bready, 1'b0);
            m_wready = 1'b1;
            tick();
            m_wready = 1'b0;
        end
        chk("b_no_w", m_wvalid, 1'b0);
        chk("b_ready", m_bready, 1'b1);
        chk("b_no_over", axi_wr_over_o, 1'b0);
        m_bvalid = 1'b1; m_bresp = bresp;
        if (bresp != 2'b00) exp_err = 1'b1;
        tick();
        m_bvalid = 1'b0; m_bresp = 2'b00;
        chk("wr_over", axi_wr_over_o, 1'b1);
        chk("wr_over_wait", core_WAIT_o, 1'b1);
        chk("wr_err", axi_err_o, exp_err);
        tick();
        chk("wr_over_pulse", axi_wr_over_o, 1'b0);
        chk("wr_idle_wait", core_WAIT_o, 1'b0);
        chk("wr_data_hold", axi_data_o, exp_data);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) tick();
        chk("rst_buses", {m_araddr, m_awaddr, m_wdata, m_arlen, m_awlen, m_arsize, m_awsize,
                          m_arburst, m_awburst, m_wstrb}, '0);
        chk("rst_ctrl", {m_arvalid, m_awvalid, m_wvalid, m_wlast, m_rready, m_bready,
                         axi_rd_over_o, axi_wr_over_o, core_WAIT_o, axi_err_o}, '0);
        chk("rst_line", axi_data_o, '0);
        rst_n = 1'b1;
        tick();
        chk("idle_wait", core_WAIT_o, 1'b0);

        read_txn(32'h8000_0014, 0, -1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("tp_line", axi_data_o, 128'h44444444_33333333_22222222_11111111);

        write_txn(32'h0000_0100, {{4{8'hDD}}, {4{8'hCC}}, {4{8'hBB}}, {4{8'hAA}}}, 1, 2, 2'b00, -1);

        read_txn(32'h1234_5678, 3, -1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

        read_txn(32'hCAFE_0000, 0, 2, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        write_txn(32'h0000_2040, {$urandom, $urandom, $urandom, $urandom}, -1, 0, 2'b00, -1);
        chk("err_sticky", axi_err_o, 1'b1);

        read_txn(32'h0000_0A00, 1, -1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0B0C);
        read_txn(32'h0000_0B0C, 0, -1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);

        write_txn(32'h0000_3000, {$urandom, $urandom, $urandom, $urandom}, -1, 0, 2'b00, 2);
        read_txn(32'h0000_4444, 0, -1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("err_cleared", axi_err_o, 1'b0);

        for (int n = 0; n < 10; n++) begin
            if ($urandom_range(0, 1) == 1)
                read_txn($urandom, int'($urandom_range(0, 3)),
                         ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : -1,
                         1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
            else
                write_txn($urandom, {$urandom, $urandom, $urandom, $urandom},
                          int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                          ($urandom_range(0, 7) == 0) ? 2'b10 : 2'b00, -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axi_line_master.md
# axi_line_master

Cache-line AXI4 master that forms the interface end of the bus controller's request channel. It accepts one single-cycle line request (read or write, 128 bits), executes it as a 4-beat 32-bit AXI4 INCR burst, and returns read data plus a single-cycle completion pulse. While a transaction is in flight it asserts `core_WAIT_o`, which the bus controller forwards to stall both caches.

## Interface
Parameters:
- `ADDR_W`, 32, AXI address width
- `DATA_W`, 32, AXI data width
- `LINE_W`, 128, cache line width; `BEATS = LINE_W/DATA_W` = 4

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  reset; synchronous, active-low
- `bc_valid_req_i`  in  1  one-cycle request strobe
- `bc_rw_i`  in  1  1 = read, 0 = write
- `bc_addr_i`  in  32  line address; bits [3:0] are ignored and forced to 0
- `bc_data_i`  in  128  write line
- `axi_data_o`  out  128  read line, valid with `axi_rd_over_o`
- `axi_rd_over_o` / `axi_wr_over_o`  out  1  one-cycle completion pulses
- `core_WAIT_o`  out  1  transaction in flight
- `axi_err_o`  out  1  sticky error flag
- `m_araddr[31:0]`, `m_arlen[7:0]`, `m_arsize[2:0]`, `m_arburst[1:0]`, `m_arvalid` out; `m_arready` in
- `m_rdata[31:0]`, `m_rresp[1:0]`, `m_rlast`, `m_rvalid` in; `m_rready` out
- `m_awaddr[31:0]`, `m_awlen[7:0]`, `m_awsize[2:0]`, `m_awburst[1:0]`, `m_awvalid` out; `m_awready` in
- `m_wdata[31:0]`, `m_wstrb[3:0]`, `m_wlast`, `m_wvalid` out; `m_wready` in
- `m_bresp[1:0]`, `m_bvalid` in; `m_bready` out

## Operation
- FSM states: IDLE, AR, R, AW, W, B.
- In IDLE, `bc_valid_req_i` latches the address, the rw bit and the write line, then moves to AR (read) or AW (write). A strobe outside IDLE is ignored and no state changes.
- AR: `m_arvalid`=1, `m_arlen`=3, `m_arsize`=2, `m_arburst`=INCR. Hold until `m_arready`, then go to R.
- R: `m_rready`=1. On each `m_rvalid`, store `m_rdata` into line slice `[32*cnt +: 32]` (beat 0 = bits [31:0]) and increment the 2-bit `cnt`. The 4th beat completes the transaction regardless of `m_rlast`.
- AW: same attributes as AR. After `m_awready`, go to W. W never starts before the AW handshake.
- W: `m_wvalid`=1, `m_wstrb`=4'hF, `m_wdata` = slice `cnt`, `m_wlast`=1 only when `cnt`==3. Advance `cnt` on `m_wready`. After the 4th beat go to B.
- B: `m_bready`=1. On `m_bvalid`, go to IDLE.
- Each AXI valid is held until its handshake. Address and data are stable while valid is high.
- `axi_err_o` is set, and held until reset, by any of:
  - `m_rresp`≠0 on any beat, or `m_bresp`≠0;
  - `m_rlast` not matching `cnt`==3.
- A transaction completes normally even when an error is flagged.

## Timing
- Reset values: all outputs 0, including `axi_data_o`. `m_arburst`/`m_awburst` also reset to 0. State = IDLE, `cnt`=0. A reset mid-burst drops every valid at the reset edge, with no completion pulse.
- AR/AW/W valids and the over pulses are registered.
- `core_WAIT_o` = (state ≠ IDLE) | over pulse. It rises the cycle after the request strobe and falls the cycle after the over pulse.
- Read latency, with `arready`=1 and `rvalid` every cycle: strobe at edge 0; `arvalid` high in cycle 1; R beats in cycles 2–5; `axi_rd_over_o` and `axi_data_o` valid in cycle 6. Same-cycle strobe-to-arvalid is not allowed.
- Write latency with zero-wait slaves: AW in cycle 1, W in cycles 2–5, B in cycle 6, `axi_wr_over_o` in cycle 7.
- The FSM returns to IDLE in the same cycle as the over pulse, so a new strobe in that cycle is accepted.
- `axi_data_o` holds its value until the next read completes.

## Structure
- `axi_pkg`: BURST_INCR=2'b01, SIZE_4B=3'd2, LEN_LINE=8'd3, RESP_OKAY=2'b00, and the state enum/localparams.
- Single module, with no sub-module. The line buffer is shared between read assembly and write slicing.

## Test plan
- Read of 0x8000_0014, zero-wait slave returning 0x11111111/0x22222222/0x33333333/0x44444444:
  - `m_araddr`=0x8000_0010, `arlen`=3;
  - `axi_data_o`=0x44444444_33333333_22222222_11111111 with `axi_rd_over_o` in cycle 6;
  - `core_WAIT_o` high in cycles 1–6.
- Write of line 0xDDDD…_CCCC…_BBBB…_AAAA… to 0x100 with `m_wready` stalled 2 cycles on beat 1:
  - W beats are AAAA, BBBB, CCCC, DDDD;
  - `m_wlast` only on DDDD;
  - `axi_wr_over_o` one cycle after `bvalid`.
- `m_arready` low for 3 cycles: `m_arvalid` and `m_araddr` are held stable, and there is no R-state activity.
- `m_rresp`=2'b10 on beat 2: the read still completes with data, and `axi_err_o` goes to 1 and stays 1 through the next OKAY transaction.
- Second strobe during R is ignored, and a strobe in the same cycle as `axi_rd_over_o` starts a new AR in the next cycle.
- `rst_n` low during W beat 2: all valids go to 0 at the reset edge, there is no over pulse, and a following read works normally.
